// File: rtl/request_encoder_8to3.sv
// Registered 8-to-3 request encoder: captures rising edges on eight request lines
// and grants one pending index at a time over a valid/ack handshake. Optional ROUND_ROBIN_EN.
module request_encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ack,
    output logic [7:0] pending
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_req_q;
    logic [7:0] r_pending;
    logic [2:0] r_code;

    logic [7:0] w_set;
    logic [7:0] w_clear;
    logic [2:0] w_base;
    logic [2:0] w_sel;
    logic       w_found;

    // Clear is applied before set, so a fresh edge on the acked bit keeps it pending.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign w_set[gi]   = en & req[gi] & ~r_req_q[gi];
            assign w_clear[gi] = (r_state == S_GRANT) & ack & (r_code == 3'(gi));
        end
    endgenerate

`ifdef ROUND_ROBIN_EN
    logic [2:0] r_ptr;
    assign w_base = r_ptr;
`else
    assign w_base = 3'd0;
`endif

    // Search downward from base-1, wrapping, ending at base; base 0 gives 7..0.
    always_comb begin
        w_sel   = 3'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!w_found && r_pending[w_base - 3'(k)]) begin
                w_sel   = w_base - 3'(k);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_req_q   <= 8'd0;
            r_pending <= 8'd0;
            r_code    <= 3'd0;
`ifdef ROUND_ROBIN_EN
            r_ptr     <= 3'd0;
`endif
        end else begin
            r_req_q   <= req;
            r_pending <= (r_pending & ~w_clear) | w_set;
            case (r_state)
                S_IDLE: begin
                    if (en && w_found) begin
                        r_code  <= w_sel;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (ack) begin
                        r_state <= S_IDLE;
`ifdef ROUND_ROBIN_EN
                        r_ptr   <= r_code;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign code    = r_code;
    assign valid   = (r_state == S_GRANT);
    assign pending = r_pending;

endmodule
